// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Gate-level 1-bit full adder; the single arithmetic cell the serial adder reuses each cycle.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic axb;
  logic gen;
  logic prop;

  xor u_xor_ab  (axb, a, b);
  xor u_xor_sum (s, axb, ci);
  and u_and_gen (gen, a, b);
  and u_and_prp (prop, axb, ci);
  or  u_or_co   (co, gen, prop);

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: captures A, B, C0 on start, adds one bit per cycle LSB-first
// through a single full-adder cell, and pulses done when the WIDTH-bit sum is complete.
//
// Handshake: start is a request sampled on each rising edge. It is accepted only in
// IDLE or DONE (busy=0); while busy=1 it is ignored. done is a one-cycle qualifier
// for S/C1, which then hold their value until the next accepted start.
module serial_adder_controller
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C1,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             sum_d;
  logic             carry_d;

  full_adder_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (sum_d),
    .co (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            c_q     <= C0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
          s_q   <= {sum_d, s_q[WIDTH-1:1]};
          c_q   <= carry_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The carry register doubles as C1: after the last shift it holds the final carry.
  assign busy        = busy_q;
  assign done        = done_q;
  assign S           = s_q;
  assign C1          = c_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Randomized self-checking bench for serial_adder_controller (WIDTH=8) against an arithmetic model.
module tb_serial_adder_controller;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C0;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         C1;
  logic [1:0]   dbg_state;

  int n_vectors;
  int n_miscompares;

  logic [W:0] exp_q[$];
  logic [W:0] last_exp;

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .C0          (C0),
    .busy        (busy),
    .done        (done),
    .S           (S),
    .C1          (C1),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge. Issues one start, optionally re-pulses start with 0xFF
  // operands at cycle glitch_at while busy, and returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0,
                        input int glitch_at);
    int         j;
    int         nb;
    bit         seen;
    logic [W:0] e;
    start = 1'b1;
    A     = a;
    B     = b;
    C0    = c0;
    exp_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(c0));
    @(posedge clk);
    @(negedge clk);
    j    = 0;
    nb   = 0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (t > 0) @(negedge clk);
      j++;
      if (j == 1) check_eq("busy_after_start", 32'(busy), 32'd1);
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
      end else if (j == glitch_at) begin
        start = 1'b1;
        A     = 8'hFF;
        B     = 8'hFF;
        C0    = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        C0    = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check_eq("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      last_exp = e;
      check_eq("done_latency", 32'(j), 32'(W + 1));
      check_eq("busy_cycles", 32'(nb), 32'(W));
      check_eq("sum", 32'(S), 32'(e[W-1:0]));
      check_eq("carry_out", 32'(C1), 32'(e[W]));
      check_eq("state_done", 32'(dbg_state), 32'd2);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_state", 32'(dbg_state), 32'd0);
    check_eq("hold_sum", 32'(S), 32'(last_exp[W-1:0]));
    check_eq("hold_carry", 32'(C1), 32'(last_exp[W]));
  endtask

  task automatic reset_outputs_check(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_sum"}, 32'(S), 32'd0);
    check_eq({tag, "_carry"}, 32'(C1), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int n_done;
    int n_busy;
    n_vectors     = 0;
    n_miscompares = 0;
    last_exp      = '0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    C0    = 1'b0;
    repeat (2) @(negedge clk);
    reset_outputs_check("reset");

    // First start in the same cycle reset is released: accepted on the next edge.
    rst_n = 1'b1;
    run_op(8'h00, 8'h00, 1'b0, 0);
    idle_check();
    run_op(8'hFF, 8'h01, 1'b0, 0);
    idle_check();
    run_op(8'hA5, 8'h5A, 1'b1, 0);
    idle_check();
    run_op(8'h12, 8'h34, 1'b0, 3);
    idle_check();

    // Back-to-back: second start issued during the DONE cycle.
    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'h03, 8'h04, 1'b0, 0);
    idle_check();

    // Reset asserted in the 4th SHIFT cycle must clear outputs without a clock edge.
    start = 1'b1;
    A     = 8'h5C;
    B     = 8'h3D;
    C0    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_shift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_outputs_check("async_reset");
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    n_busy = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check_eq("no_done_after_abort", 32'(n_done), 32'd0);
    check_eq("no_busy_after_abort", 32'(n_busy), 32'd0);
    last_exp = '0;
    check_eq("abort_sum_cleared", 32'(S), 32'd0);

    // Randomized operands, random in-flight start pulses and random back-to-back spacing.
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, W)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
SERIAL_ADDER_CONTROLLER -- requirements
Module: serial_adder_controller

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; the block SHALL support any WIDTH from 2 to 32.
REQ-002 Port: clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 Port: start, input, 1, request to begin an addition; sampled on the rising edge of clk.
REQ-005 Port: A, input, WIDTH, operand A; captured when start is accepted.
REQ-006 Port: B, input, WIDTH, operand B; captured when start is accepted.
REQ-007 Port: C0, input, 1, carry-in; captured when start is accepted.
REQ-008 Port: busy, output, 1; high while bits are being processed.
REQ-009 Port: done, output, 1; one-cycle pulse when the result is complete.
REQ-010 Port: S, output, WIDTH, registered sum.
REQ-011 Port: C1, output, 1, registered carry-out.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture A, B and C0 into shift/carry registers, clear the bit counter and enter SHIFT.
REQ-014 In SHIFT, each cycle SHALL add the LSBs of the A and B shift registers plus the carry register through one full-adder cell.
REQ-015 In the same SHIFT cycle, the block SHALL:
- shift the sum bit into the MSB of the S shift register (right shift);
- store the cell carry into the carry register;
- shift A and B right by one;
- increment the counter.
REQ-016 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE. On that edge, S SHALL hold the full sum and C1 the final carry.
REQ-017 Latency: with start accepted at edge N, done SHALL be high during cycle N+WIDTH+1, i.e. after edge N+WIDTH. For WIDTH=8, done rises 9 edges after the start edge.
REQ-018 done SHALL be high only in DONE, for exactly one cycle.
- Without start, DONE SHALL go to IDLE.
- With start, DONE SHALL go directly to SHIFT (back-to-back operation).
REQ-019 busy SHALL be high only in SHIFT.
REQ-020 start SHALL be ignored while in SHIFT. The operand registers SHALL NOT change during SHIFT.
REQ-021 S and C1 SHALL hold their last result in IDLE and DONE.
- S and C1 are undefined-but-stable during SHIFT (partial shift contents).
- Consumers SHALL qualify S and C1 with done.
REQ-022 The sum SHALL be (A + B + C0) mod 2^WIDTH, and C1 SHALL be bit WIDTH of that sum. There is no overflow flag.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-024 When rst_n=0, asynchronously and regardless of clock:
- state SHALL be IDLE;
- busy=0, done=0, S=0, C1=0;
- the counter, carry and operand registers SHALL be 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-027 Shared package serial_adder_pkg SHALL hold:
- the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
- the WIDTH default.
REQ-028 The 1-bit combinational adder SHALL be a separate gate-level sub-module full_adder_cell (inputs a, b, ci; outputs s, co), instantiated once.
REQ-029 All outputs SHALL be driven from registers; there SHALL be no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-030 Zero case: A=0x00, B=0x00, C0=0, one-cycle start.
- S=0x00, C1=0.
- done pulses exactly one cycle, 9 edges after start.
- busy is high for exactly 8 cycles.
REQ-031 Carry ripple: A=0xFF, B=0x01, C0=0 -> S=0x00, C1=1.
REQ-032 Carry-in: A=0xA5, B=0x5A, C0=1 -> S=0x00, C1=1.
REQ-033 Start while busy:
- start A=0x12, B=0x34, C0=0;
- pulse start with A=0xFF, B=0xFF at cycle 3.
- Required response: result S=0x46, C1=0; the second start is ignored.
REQ-034 Reset mid-operation and back-to-back:
- Reset mid-operation: assert rst_n=0 at cycle 4 of SHIFT. Required: busy=0, done=0, S=0x00 immediately (asynchronously); no done pulse follows.
- Back-to-back: a new start A=0x03, B=0x04, C0=0 applied in the DONE cycle of a prior op. Required: busy=1 on the next edge; S=0x07, C1=0 with done 9 edges later.
